// File: rtl/clk_reconfig_ctrl.sv
// Purpose: rewrites the PLL CLKOUT0 divider over DRP (read-modify-write) with the PLL held in reset, then gates core reset on stable lock.
// Latency: RST_CYCLES+1 cycles from request to first DRP access, 4 cycles per register step with zero-wait DRP, 2+LOCK_STABLE cycles lock-to-release.
// Backpressure: i_req is only sampled in IDLE; DRP waits on i_drp_drdy (bounded by DRDY_TIMEOUT), lock wait bounded by LOCK_TIMEOUT.
module clk_reconfig_ctrl #(
    parameter int RST_CYCLES   = 4,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [6:0]  i_div,
    input  logic        i_locked,
    output logic        o_pll_rst,
    output logic [6:0]  o_drp_addr,
    output logic [15:0] o_drp_di,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_rst_core
);

    // ClkReg1 holds HIGH_TIME/LOW_TIME; ClkReg2 holds EDGE/NO_COUNT which must be cleared for an even divide.
    localparam logic [6:0]  ADDR_CLKREG1 = 7'h08;
    localparam logic [6:0]  ADDR_CLKREG2 = 7'h09;
    localparam logic [15:0] KEEP_CLKREG1 = 16'hF000;
    localparam logic [15:0] KEEP_CLKREG2 = 16'hFF3F;

    localparam int LCW = $clog2(LOCK_STABLE + 1);

    localparam logic [16:0]    RST_LAST      = 17'(RST_CYCLES - 1);
    localparam logic [16:0]    DRDY_LAST     = 17'(DRDY_TIMEOUT - 1);
    localparam logic [16:0]    LOCK_TMO_LAST = 17'(LOCK_TIMEOUT - 1);
    localparam logic [LCW-1:0] LOCK_CNT_LAST = LCW'(LOCK_STABLE - 1);
    localparam logic [LCW-1:0] LOCK_CNT_ONE  = LCW'(1);

    typedef enum logic [3:0] {
        S_LOCKWAIT = 4'd0,
        S_IDLE     = 4'd1,
        S_RSTHOLD  = 4'd2,
        S_RD       = 4'd3,
        S_RDWAIT   = 4'd4,
        S_WR       = 4'd5,
        S_WRWAIT   = 4'd6,
        S_RELEASE  = 4'd7,
        S_ERR      = 4'd8
    } state_t;

    state_t state;
    state_t state_nxt;

    logic           lock_meta;
    logic           lock_sync;
    logic [16:0]    tmo_cnt;
    logic [LCW-1:0] lock_cnt;
    logic           step_k;
    logic           step_nxt;
    logic [6:0]     div_q;
    logic           from_release;

    logic           div_ok;
    logic           accept;
    logic           lock_hit;
    logic           tmo_counting;

    logic [6:0]     step_addr;
    logic [15:0]    step_keep;
    logic [15:0]    step_ins;

    logic           pll_rst_nxt;
    logic [6:0]     drp_addr_nxt;
    logic [15:0]    drp_di_nxt;
    logic           drp_den_nxt;
    logic           drp_dwe_nxt;
    logic           busy_nxt;
    logic           done_nxt;
    logic           err_nxt;
    logic           rst_core_nxt;

    // Two-flop synchronizer for the asynchronous PLL LOCKED output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= i_locked;
            lock_sync <= lock_meta;
        end
    end

    // Even, non-zero divides only; 126 is the largest even 7-bit value.
    assign div_ok       = ~i_div[0] && (i_div != 7'd0) && (i_div <= 7'd126);
    assign accept       = (state == S_IDLE) && i_req && div_ok;
    assign lock_hit     = lock_sync && (lock_cnt == LOCK_CNT_LAST);
    assign tmo_counting = (state == S_RSTHOLD) || (state == S_RDWAIT) ||
                          (state == S_WRWAIT)  || (state == S_LOCKWAIT);

    // Step index as it will be after this edge; only advances when step 0's write completes.
    always_comb begin
        step_nxt = step_k;
        if (accept) begin
            step_nxt = 1'b0;
        end else if ((state == S_WRWAIT) && i_drp_drdy && !step_k) begin
            step_nxt = 1'b1;
        end
    end

    // Per-step register address, preserved bits and inserted field.
    always_comb begin
        step_addr = step_nxt ? ADDR_CLKREG2 : ADDR_CLKREG1;
        step_keep = step_nxt ? KEEP_CLKREG2 : KEEP_CLKREG1;
        step_ins  = step_nxt ? 16'h0000 : {4'b0000, div_q[6:1], div_q[6:1]};
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_LOCKWAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; DRDY and lock waits fall through to ERR when their budget runs out.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_RSTHOLD;
                end else if (!lock_sync) begin
                    state_nxt = S_LOCKWAIT;
                end
            end
            S_RSTHOLD: begin
                if (tmo_cnt == RST_LAST) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: state_nxt = S_RDWAIT;
            S_RDWAIT: begin
                if (i_drp_drdy) begin
                    state_nxt = S_WR;
                end else if (tmo_cnt == DRDY_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_WR: state_nxt = S_WRWAIT;
            S_WRWAIT: begin
                if (i_drp_drdy) begin
                    state_nxt = step_k ? S_RELEASE : S_RD;
                end else if (tmo_cnt == DRDY_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_RELEASE: state_nxt = S_LOCKWAIT;
            S_LOCKWAIT: begin
                if (lock_hit) begin
                    state_nxt = S_IDLE;
                end else if (tmo_cnt == LOCK_TMO_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_ERR: state_nxt = S_IDLE;
            default: state_nxt = S_LOCKWAIT;
        endcase
    end

    // Output decode on state entry so every output can be registered without a cycle of lag.
    always_comb begin
        pll_rst_nxt  = o_pll_rst;
        drp_addr_nxt = o_drp_addr;
        drp_di_nxt   = o_drp_di;
        drp_den_nxt  = 1'b0;
        drp_dwe_nxt  = 1'b0;
        busy_nxt     = (state_nxt != S_IDLE);
        done_nxt     = 1'b0;
        err_nxt      = o_err;
        rst_core_nxt = o_rst_core;

        if (state_nxt != state) begin
            unique case (state_nxt)
                S_RSTHOLD: begin
                    err_nxt      = 1'b0;
                    pll_rst_nxt  = 1'b1;
                    rst_core_nxt = 1'b1;
                end
                S_RD: begin
                    drp_den_nxt  = 1'b1;
                    drp_addr_nxt = step_addr;
                end
                S_WR: begin
                    drp_den_nxt  = 1'b1;
                    drp_dwe_nxt  = 1'b1;
                    drp_addr_nxt = step_addr;
                    drp_di_nxt   = (i_drp_do & step_keep) | step_ins;
                end
                S_RELEASE: begin
                    pll_rst_nxt = 1'b0;
                end
                S_LOCKWAIT: begin
                    rst_core_nxt = 1'b1;
                end
                S_IDLE: begin
                    // Only a completed lock wait releases the core; ERR leaves it held.
                    if (state == S_LOCKWAIT) begin
                        rst_core_nxt = 1'b0;
                        done_nxt     = from_release;
                    end
                end
                S_ERR: begin
                    err_nxt      = 1'b1;
                    pll_rst_nxt  = 1'b0;
                    rst_core_nxt = 1'b1;
                end
                default: ;
            endcase
        end

        // A bad divide is flagged without touching the PLL or the core reset.
        if ((state == S_IDLE) && i_req && !div_ok) begin
            err_nxt = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pll_rst  <= 1'b0;
            o_drp_addr <= 7'd0;
            o_drp_di   <= 16'd0;
            o_drp_den  <= 1'b0;
            o_drp_dwe  <= 1'b0;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_rst_core <= 1'b1;
        end else begin
            o_pll_rst  <= pll_rst_nxt;
            o_drp_addr <= drp_addr_nxt;
            o_drp_di   <= drp_di_nxt;
            o_drp_den  <= drp_den_nxt;
            o_drp_dwe  <= drp_dwe_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
            o_err      <= err_nxt;
            o_rst_core <= rst_core_nxt;
        end
    end

    // Shared wait counter: restarts on every state change and only runs in waiting states.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt <= 17'd0;
        end else if ((state_nxt != state) || !tmo_counting) begin
            tmo_cnt <= 17'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 17'd1;
        end
    end

    // Consecutive-lock counter; any low sample or leaving LOCKWAIT restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_cnt <= '0;
        end else if ((state != S_LOCKWAIT) || (state_nxt != S_LOCKWAIT) || !lock_sync) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt + LOCK_CNT_ONE;
        end
    end

    // Sequence context: captured divide, step index and whether this lock wait follows a reconfiguration.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q        <= 7'd0;
            step_k       <= 1'b0;
            from_release <= 1'b0;
        end else begin
            step_k <= step_nxt;
            if (accept) begin
                div_q <= i_div;
            end
            if ((state_nxt == S_LOCKWAIT) && (state != S_LOCKWAIT)) begin
                from_release <= (state == S_RELEASE);
            end
        end
    end

endmodule

// File: tb/tb_clk_reconfig_ctrl.sv
// Purpose: directed bench for clk_reconfig_ctrl with a responsive DRP model and hand-driven PLL lock.
// Latency: checks request-to-DRP, per-step and lock-to-release cycle counts against fixed offsets.
// Backpressure: DRP model can withhold drdy for reads or writes to exercise the timeouts.
module tb_clk_reconfig_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_req;
    logic [6:0]  i_div;
    logic        i_locked;
    logic        o_pll_rst;
    logic [6:0]  o_drp_addr;
    logic [15:0] o_drp_di;
    logic        o_drp_den;
    logic        o_drp_dwe;
    logic [15:0] i_drp_do;
    logic        i_drp_drdy;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_rst_core;

    clk_reconfig_ctrl dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_div      (i_div),
        .i_locked   (i_locked),
        .o_pll_rst  (o_pll_rst),
        .o_drp_addr (o_drp_addr),
        .o_drp_di   (o_drp_di),
        .o_drp_den  (o_drp_den),
        .o_drp_dwe  (o_drp_dwe),
        .i_drp_do   (i_drp_do),
        .i_drp_drdy (i_drp_drdy),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_rst_core (o_rst_core)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // DRP model: PLL registers 0x08/0x09, drdy one cycle after den, with optional silence.
    logic [15:0] reg08;
    logic [15:0] reg09;
    logic        rd_en;
    logic        wr_en;
    logic        pend;
    logic [15:0] pend_do;
    int          den_n;
    int          den_t [0:15];
    int          wlog_n;
    logic [6:0]  wlog_addr [0:7];
    logic [15:0] wlog_data [0:7];
    logic        wlog_prst [0:7];

    initial begin
        pend    = 1'b0;
        pend_do = 16'h0000;
        forever begin
            @(posedge i_clk);
            #1;
            i_drp_drdy = pend;
            i_drp_do   = pend_do;
            pend       = 1'b0;
            if (o_drp_den) begin
                if (den_n < 16) den_t[den_n] = cyc;
                den_n++;
                if (o_drp_dwe) begin
                    if (wlog_n < 8) begin
                        wlog_addr[wlog_n] = o_drp_addr;
                        wlog_data[wlog_n] = o_drp_di;
                        wlog_prst[wlog_n] = o_pll_rst;
                    end
                    wlog_n++;
                    if (o_drp_addr == 7'h08) reg08 = o_drp_di;
                    if (o_drp_addr == 7'h09) reg09 = o_drp_di;
                    pend = wr_en;
                end else begin
                    pend_do = (o_drp_addr == 7'h08) ? reg08 :
                              (o_drp_addr == 7'h09) ? reg09 : 16'h0000;
                    pend = rd_en;
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, " pll_rst"},  {31'd0, o_pll_rst},  32'd0);
        chk({tag, " rst_core"}, {31'd0, o_rst_core}, 32'd1);
        chk({tag, " busy"},     {31'd0, o_busy},     32'd1);
        chk({tag, " done"},     {31'd0, o_done},     32'd0);
        chk({tag, " err"},      {31'd0, o_err},      32'd0);
        chk({tag, " den"},      {31'd0, o_drp_den},  32'd0);
        chk({tag, " dwe"},      {31'd0, o_drp_dwe},  32'd0);
        chk({tag, " addr"},     {25'd0, o_drp_addr}, 32'd0);
        chk({tag, " di"},       {16'd0, o_drp_di},   32'd0);
    endtask

    // Waits for o_rst_core to fall; reports the cycle (-1 on timeout) and o_done activity.
    task automatic wait_core_fall(input int limit, output int at, output int done_n, output logic done_at);
        at      = -1;
        done_n  = 0;
        done_at = 1'b0;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (o_done) done_n++;
            if (!o_rst_core) begin
                at      = cyc;
                done_at = o_done;
                break;
            end
        end
    endtask

    task automatic wait_pll_rst_low(input int limit, output int at);
        at = -1;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (!o_pll_rst) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_err_high(input int limit, output int at);
        at = -1;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (o_err) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Runs the rest of an accepted reconfiguration with zero-wait DRP, then locks (optionally with one glitch).
    task automatic run_seq(input logic [15:0] exp08, input int acc, input int glitch);
        int   rel;
        int   rise;
        int   at;
        int   dn;
        logic dat;
        i_locked = 1'b0;
        wait_pll_rst_low(100, rel);
        chk("pll_rst release offset", rel - acc, 32'd12);
        chk("den count", den_n, 32'd4);
        chk("first den offset", den_t[0] - acc, 32'd4);
        chk("step period", den_t[2] - den_t[0], 32'd4);
        chk("write count", wlog_n, 32'd2);
        chk("write0 addr", {25'd0, wlog_addr[0]}, 32'h08);
        chk("write0 data", {16'd0, wlog_data[0]}, {16'd0, exp08});
        chk("write1 addr", {25'd0, wlog_addr[1]}, 32'h09);
        chk("write1 data", {16'd0, wlog_data[1]}, 32'h0005);
        chk("pll_rst during writes", {30'd0, wlog_prst[0], wlog_prst[1]}, 32'd3);
        repeat (3) tick();
        i_locked = 1'b1;
        rise = cyc;
        if (glitch > 0) begin
            repeat (glitch) tick();
            i_locked = 1'b0;
            tick();
            i_locked = 1'b1;
            rise = cyc;
        end
        wait_core_fall(200, at, dn, dat);
        chk("lock to core release", at - rise, 32'd18);
        chk("done with core release", {31'd0, dat}, 32'd1);
        chk("done pulse count", dn, 32'd1);
        tick();
        chk("done single cycle", {31'd0, o_done}, 32'd0);
        chk("idle after seq", {31'd0, o_busy}, 32'd0);
    endtask

    typedef struct {
        logic [6:0]  div;
        logic        valid;
        logic [15:0] exp08;
    } vec_t;

    vec_t tbl [0:6];

    initial begin
        int   acc;
        int   at;
        int   dn;
        int   d;
        int   rel;
        int   busy_low;
        logic dat;
        logic core_before;

        tbl[0] = '{7'd33,  1'b0, 16'h0000};
        tbl[1] = '{7'd0,   1'b0, 16'h0000};
        tbl[2] = '{7'd127, 1'b0, 16'h0000};
        tbl[3] = '{7'd32,  1'b1, 16'hA410};
        tbl[4] = '{7'd2,   1'b1, 16'hA041};
        tbl[5] = '{7'd126, 1'b1, 16'hAFFF};
        tbl[6] = '{7'd64,  1'b1, 16'hA820};

        i_rst      = 1'b1;
        i_req      = 1'b0;
        i_div      = 7'd0;
        i_locked   = 1'b1;
        i_drp_do   = 16'h0000;
        i_drp_drdy = 1'b0;
        reg08      = 16'hA7FF;
        reg09      = 16'h00C5;
        rd_en      = 1'b1;
        wr_en      = 1'b1;
        den_n      = 0;
        wlog_n     = 0;

        repeat (3) tick();
        check_reset_vals("reset");

        // Power-up with lock already present: core released after sync + stable window, no done.
        i_rst = 1'b0;
        rel = cyc;
        wait_core_fall(100, at, dn, dat);
        chk("powerup core release", at - rel, 32'd18);
        chk("powerup no done", dn, 32'd0);
        chk("powerup idle", {31'd0, o_busy}, 32'd0);

        // Request table: invalid divides flag o_err only; valid ones run the full sequence.
        for (int i = 0; i < 7; i++) begin
            den_n       = 0;
            wlog_n      = 0;
            core_before = o_rst_core;
            i_div       = tbl[i].div;
            i_req       = 1'b1;
            tick();
            acc   = cyc;
            i_req = 1'b0;
            chk($sformatf("req%0d busy", i),    {31'd0, o_busy},    {31'd0, tbl[i].valid});
            chk($sformatf("req%0d pll_rst", i), {31'd0, o_pll_rst}, {31'd0, tbl[i].valid});
            chk($sformatf("req%0d err", i),     {31'd0, o_err},     {31'd0, !tbl[i].valid});
            if (!tbl[i].valid) begin
                tick();
                tick();
                chk($sformatf("req%0d no den", i),       den_n, 32'd0);
                chk($sformatf("req%0d pll_rst low", i),  {31'd0, o_pll_rst},  32'd0);
                chk($sformatf("req%0d core kept", i),    {31'd0, o_rst_core}, {31'd0, core_before});
            end else begin
                run_seq(tbl[i].exp08, acc, 0);
            end
        end

        // DRP never answers: ERR 64 cycles after entering RDWAIT, then IDLE with core held.
        rd_en  = 1'b0;
        den_n  = 0;
        wlog_n = 0;
        i_div  = 7'd32;
        i_req  = 1'b1;
        tick();
        acc   = cyc;
        i_req = 1'b0;
        wait_err_high(200, at);
        chk("drdy timeout offset", at - acc, 32'd69);
        chk("drdy timeout pll_rst", {31'd0, o_pll_rst},  32'd0);
        chk("drdy timeout rst_core", {31'd0, o_rst_core}, 32'd1);
        tick();
        chk("after err idle", {31'd0, o_busy}, 32'd0);
        chk("after err sticky", {31'd0, o_err}, 32'd1);
        chk("after err core held", {31'd0, o_rst_core}, 32'd1);
        chk("timeout single read", den_n, 32'd1);
        rd_en = 1'b1;

        // Retry clears o_err; a lock glitch 10 cycles into the window restarts the stable count.
        den_n  = 0;
        wlog_n = 0;
        i_req  = 1'b1;
        tick();
        acc   = cyc;
        i_req = 1'b0;
        chk("retry clears err", {31'd0, o_err}, 32'd0);
        run_seq(16'hA410, acc, 10);

        // i_req held high, reset pulsed while waiting for write drdy.
        wr_en    = 1'b0;
        den_n    = 0;
        wlog_n   = 0;
        busy_low = 0;
        i_req    = 1'b1;
        tick();
        acc = cyc;
        while (cyc < acc + 9) begin
            if (!o_busy) busy_low++;
            tick();
        end
        chk("held req no re-accept", busy_low, 32'd0);
        chk("pll_rst before reset", {31'd0, o_pll_rst}, 32'd1);
        chk("dens before reset", den_n, 32'd2);
        i_rst = 1'b1;
        #1;
        check_reset_vals("midseq reset");
        i_req = 1'b0;
        tick();
        i_rst = 1'b0;
        rel   = cyc;
        wr_en = 1'b1;
        wait_core_fall(100, at, dn, dat);
        chk("post reset core release", at - rel, 32'd18);
        chk("post reset no done", dn, 32'd0);

        // Lock lost in IDLE and never returns: LOCKWAIT then ERR after LOCK_TIMEOUT.
        i_locked = 1'b0;
        d = cyc;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (o_rst_core) break;
        end
        chk("lock loss core reset offset", cyc - d, 32'd3);
        chk("lock loss busy", {31'd0, o_busy}, 32'd1);
        wait_err_high(70000, at);
        chk("lock timeout offset", at - d, 32'd65539);
        chk("lock timeout pll_rst", {31'd0, o_pll_rst}, 32'd0);
        chk("lock timeout rst_core", {31'd0, o_rst_core}, 32'd1);
        tick();
        chk("lock timeout idle", {31'd0, o_busy}, 32'd0);
        tick();
        chk("relock wait", {31'd0, o_busy}, 32'd1);
        i_locked = 1'b1;
        rel = cyc;
        wait_core_fall(100, at, dn, dat);
        chk("relock core release", at - rel, 32'd18);
        chk("relock no done", dn, 32'd0);
        chk("err still sticky", {31'd0, o_err}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
